// File: rtl/uart_pkg.sv
// uart_pkg: shared drain-FSM encodings and default FIFO depth
package uart_pkg;
  localparam int DEFAULT_DEPTH = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_BUSY = 2'd1, WAIT_DONE = 2'd2} tx_state_e;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write side, status and transmitter handshake of the tx fifo
interface uart_tx_fifo_if import uart_pkg::*; #(parameter int DEPTH = DEFAULT_DEPTH);
  logic [7:0] wr_data;
  logic wr_en;
  logic full;
  logic empty;
  logic [$clog2(DEPTH):0] level;
  logic overflow;
  logic [7:0] tx_din;
  logic tx_wr_en;
  logic tx_busy;
  modport master (output wr_data, wr_en, tx_busy, input full, empty, level, overflow, tx_din, tx_wr_en);
  modport slave (input wr_data, wr_en, tx_busy, output full, empty, level, overflow, tx_din, tx_wr_en);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: circular buffer with registered full/empty/level and sticky overflow
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          overflow
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  logic [LW-1:0] level_nxt;
  always_comb begin
    wr_ok = wr_en & ~full;
    rd_ok = rd_en & ~empty;
    level_nxt = level + LW'(wr_ok) - LW'(rd_ok);
  end
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= wr_data;
  // flags come from the next level so they never see wr_en combinationally
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_ok);
      rd_ptr <= rd_ptr + AW'(rd_ok);
      level <= level_nxt;
      full <= level_nxt == LW'(DEPTH);
      empty <= level_nxt == '0;
      overflow <= overflow | (wr_en & full);
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte fifo drained into a uart transmitter one frame at a time
module uart_tx_fifo import uart_pkg::*; #(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input logic clk,
  input logic rst,
  uart_tx_fifo_if.slave bus
);
  tx_state_e state, state_nxt;
  logic pop;
  logic [7:0] head;
  sync_fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(bus.wr_en),
    .wr_data(bus.wr_data),
    .rd_en(pop),
    .rd_data(head),
    .full(bus.full),
    .empty(bus.empty),
    .level(bus.level),
    .overflow(bus.overflow)
  );
  always_comb begin
    pop = state == IDLE && !bus.empty && !bus.tx_busy;
    state_nxt = state == IDLE      ? (pop ? WAIT_BUSY : IDLE) :
                state == WAIT_BUSY ? (bus.tx_busy ? WAIT_DONE : WAIT_BUSY) :
                state == WAIT_DONE ? (bus.tx_busy ? WAIT_DONE : IDLE) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus.tx_wr_en <= 1'b0;
      bus.tx_din <= 8'h00;
    end else begin
      state <= state_nxt;
      bus.tx_wr_en <= pop;
      if (pop) bus.tx_din <= head;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenario checks of uart_tx_fifo against a behavioural transmitter
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  uart_tx_fifo_if #(.DEPTH(16)) bus();
  uart_tx_fifo #(.DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic force_busy = 1'b0;
  logic prev_we = 1'b0;
  int frame = 4;
  int cnt = 0;
  int viol = 0;
  int checks = 0;
  int passed = 0;
  logic [7:0] emitted [$];
  assign bus.tx_busy = force_busy | (cnt != 0);
  always @(posedge clk) begin
    if (bus.tx_wr_en) begin
      emitted.push_back(bus.tx_din);
      if (bus.tx_busy || prev_we) viol++;
    end
    prev_we <= bus.tx_wr_en;
    cnt <= bus.tx_wr_en ? frame : (cnt != 0 ? cnt - 1 : 0);
  end

  task start_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    emitted.delete();
  endtask

  task wr(input logic [7:0] b);
    bus.wr_en = 1'b1;
    bus.wr_data = b;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task wait_emitted(input int n, input string name);
    for (int c = 0; c < 600 && emitted.size() < n; c++) @(negedge clk);
    checks++; if (emitted.size() !== n) $display("FAIL %s emitted_count got %0d want %0d", name, emitted.size(), n); else passed++;
  endtask

  task test_reset();
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.level !== 5'd0) $display("FAIL reset level got %0d want 0", bus.level); else passed++;
    checks++; if (bus.empty !== 1'b1) $display("FAIL reset empty got %b want 1", bus.empty); else passed++;
    checks++; if (bus.full !== 1'b0) $display("FAIL reset full got %b want 0", bus.full); else passed++;
    checks++; if (bus.overflow !== 1'b0) $display("FAIL reset overflow got %b want 0", bus.overflow); else passed++;
    checks++; if (bus.tx_wr_en !== 1'b0) $display("FAIL reset tx_wr_en got %b want 0", bus.tx_wr_en); else passed++;
    checks++; if (bus.tx_din !== 8'h00) $display("FAIL reset tx_din got %h want 00", bus.tx_din); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task test_single();
    frame = 3;
    start_reset();
    wr(8'hA5);
    checks++; if (bus.level !== 5'd1) $display("FAIL single level got %0d want 1", bus.level); else passed++;
    checks++; if (bus.empty !== 1'b0) $display("FAIL single empty_after_write got %b want 0", bus.empty); else passed++;
    checks++; if (bus.tx_wr_en !== 1'b0) $display("FAIL single early_pulse got %b want 0", bus.tx_wr_en); else passed++;
    @(negedge clk);
    checks++; if (bus.tx_wr_en !== 1'b1) $display("FAIL single pulse got %b want 1", bus.tx_wr_en); else passed++;
    checks++; if (bus.tx_din !== 8'hA5) $display("FAIL single tx_din got %h want a5", bus.tx_din); else passed++;
    checks++; if (bus.empty !== 1'b1) $display("FAIL single empty_after_pop got %b want 1", bus.empty); else passed++;
    @(negedge clk);
    checks++; if (bus.tx_wr_en !== 1'b0) $display("FAIL single pulse_width got %b want 0", bus.tx_wr_en); else passed++;
    checks++; if (bus.tx_din !== 8'hA5) $display("FAIL single tx_din_hold got %h want a5", bus.tx_din); else passed++;
    repeat (frame + 6) @(negedge clk);
    checks++; if (emitted.size() !== 1) $display("FAIL single emitted_count got %0d want 1", emitted.size()); else passed++;
  endtask

  task test_burst();
    frame = 4;
    start_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'(i + 1));
    checks++; if (bus.full !== 1'b1) $display("FAIL burst full got %b want 1", bus.full); else passed++;
    checks++; if (bus.level !== 5'd16) $display("FAIL burst level got %0d want 16", bus.level); else passed++;
    checks++; if (emitted.size() !== 0) $display("FAIL burst issued_while_busy got %0d want 0", emitted.size()); else passed++;
    force_busy = 1'b0;
    wait_emitted(16, "burst");
    for (int i = 0; i < 16; i++) begin
      checks++; if (emitted[i] !== 8'(i + 1)) $display("FAIL burst order[%0d] got %h want %h", i, emitted[i], 8'(i + 1)); else passed++;
    end
    repeat (frame + 6) @(negedge clk);
    checks++; if (bus.empty !== 1'b1) $display("FAIL burst empty_at_end got %b want 1", bus.empty); else passed++;
    checks++; if (viol !== 0) $display("FAIL burst handshake_violations got %0d want 0", viol); else passed++;
  endtask

  task test_overflow();
    frame = 2;
    start_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i));
    checks++; if (bus.overflow !== 1'b0) $display("FAIL overflow before_drop got %b want 0", bus.overflow); else passed++;
    wr(8'hFF);
    checks++; if (bus.overflow !== 1'b1) $display("FAIL overflow flag got %b want 1", bus.overflow); else passed++;
    checks++; if (bus.level !== 5'd16) $display("FAIL overflow level got %0d want 16", bus.level); else passed++;
    checks++; if (bus.full !== 1'b1) $display("FAIL overflow full got %b want 1", bus.full); else passed++;
    force_busy = 1'b0;
    wait_emitted(16, "overflow");
    repeat (3 * frame + 10) @(negedge clk);
    checks++; if (emitted.size() !== 16) $display("FAIL overflow extra_byte count got %0d want 16", emitted.size()); else passed++;
    for (int i = 0; i < 16; i++) begin
      checks++; if (emitted[i] !== 8'h20 + 8'(i)) $display("FAIL overflow order[%0d] got %h want %h", i, emitted[i], 8'h20 + 8'(i)); else passed++;
    end
    checks++; if (bus.overflow !== 1'b1) $display("FAIL overflow sticky got %b want 1", bus.overflow); else passed++;
  endtask

  task test_wrap();
    int exp_lvl, sent, simul;
    logic acc;
    exp_lvl = 0; sent = 0; simul = 0; acc = 1'b0;
    frame = 1;
    start_reset();
    for (int c = 0; c < 1000 && emitted.size() < 40; c++) begin
      if (acc && bus.tx_wr_en) simul++;
      exp_lvl = exp_lvl + int'(acc) - int'(bus.tx_wr_en);
      checks++; if (bus.level !== 5'(exp_lvl)) $display("FAIL wrap level cycle %0d got %0d want %0d", c, bus.level, exp_lvl); else passed++;
      acc = 1'b0;
      bus.wr_en = 1'b0;
      if (sent < 40 && c % 3 != 2 && exp_lvl < 12) begin
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h40 + 8'(sent);
        acc = !bus.full;
        sent++;
      end
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    checks++; if (emitted.size() !== 40) $display("FAIL wrap emitted_count got %0d want 40", emitted.size()); else passed++;
    for (int i = 0; i < 40; i++) begin
      checks++; if (emitted[i] !== 8'h40 + 8'(i)) $display("FAIL wrap order[%0d] got %h want %h", i, emitted[i], 8'h40 + 8'(i)); else passed++;
    end
    checks++; if (simul == 0) $display("FAIL wrap simultaneous_cycles got %0d want >0", simul); else passed++;
    checks++; if (viol !== 0) $display("FAIL wrap handshake_violations got %0d want 0", viol); else passed++;
    repeat (8) @(negedge clk);
  endtask

  task test_reset_mid();
    frame = 20;
    start_reset();
    for (int i = 0; i < 4; i++) wr(8'h81 + 8'(i));
    repeat (4) @(negedge clk);
    checks++; if (bus.level !== 5'd3) $display("FAIL midrst queued got %0d want 3", bus.level); else passed++;
    checks++; if (emitted.size() !== 1) $display("FAIL midrst first_issue got %0d want 1", emitted.size()); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.level !== 5'd0) $display("FAIL midrst level got %0d want 0", bus.level); else passed++;
    checks++; if (bus.empty !== 1'b1) $display("FAIL midrst empty got %b want 1", bus.empty); else passed++;
    checks++; if (bus.full !== 1'b0) $display("FAIL midrst full got %b want 0", bus.full); else passed++;
    checks++; if (bus.tx_wr_en !== 1'b0) $display("FAIL midrst tx_wr_en got %b want 0", bus.tx_wr_en); else passed++;
    checks++; if (bus.tx_din !== 8'h00) $display("FAIL midrst tx_din got %h want 00", bus.tx_din); else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (emitted.size() !== 1) $display("FAIL midrst spurious_issue got %0d want 1", emitted.size()); else passed++;
    checks++; if (bus.level !== 5'd0) $display("FAIL midrst level_after got %0d want 0", bus.level); else passed++;
    wr(8'h99);
    wait_emitted(2, "midrst");
    checks++; if (emitted[1] !== 8'h99) $display("FAIL midrst new_byte got %h want 99", emitted[1]); else passed++;
    checks++; if (viol !== 0) $display("FAIL midrst handshake_violations got %0d want 0", viol); else passed++;
    repeat (frame + 6) @(negedge clk);
  endtask

  task test_busy_held();
    int p;
    p = 0;
    @(negedge clk);
    rst = 1'b1;
    force_busy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    emitted.delete();
    wr(8'hB1);
    wr(8'hB2);
    repeat (10) @(negedge clk);
    checks++; if (emitted.size() !== 0) $display("FAIL busyheld issued_while_busy got %0d want 0", emitted.size()); else passed++;
    checks++; if (bus.level !== 5'd2) $display("FAIL busyheld level got %0d want 2", bus.level); else passed++;
    force_busy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.tx_wr_en) p++;
    end
    checks++; if (p !== 1) $display("FAIL busyheld pulses got %0d want 1", p); else passed++;
    checks++; if (emitted[0] !== 8'hB1) $display("FAIL busyheld first got %h want b1", emitted[0]); else passed++;
    wait_emitted(2, "busyheld");
    checks++; if (emitted[1] !== 8'hB2) $display("FAIL busyheld second got %h want b2", emitted[1]); else passed++;
    checks++; if (viol !== 0) $display("FAIL busyheld handshake_violations got %0d want 0", viol); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_busy_held();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clk and rst are as below.
REQ-002 Parameter DEPTH, default 16, FIFO depth in bytes; legal values are powers of two, 2..256.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 wr_data  input  8  byte to enqueue.
REQ-006 wr_en  input  1  enqueue strobe; one byte per cycle while high.
REQ-007 full  output  1  FIFO holds DEPTH bytes.
REQ-008 empty  output  1  FIFO holds 0 bytes.
REQ-009 level  output  clog2(DEPTH)+1  current byte count.
REQ-010 overflow  output  1  sticky; a write was dropped.
REQ-011 tx_din  output  8  byte presented to the UART transmitter.
REQ-012 tx_wr_en  output  1  single-cycle start pulse to the transmitter.
REQ-013 tx_busy  input  1  transmitter busy; goes high the cycle after an accepted tx_wr_en and stays high until the stop bit completes.

Function
REQ-014 A write SHALL be accepted when wr_en=1 and registered full=0 at the edge; the byte goes to the write pointer, and the pointer increments.
REQ-015 A write with full=1 SHALL be dropped, leave contents and pointers unchanged, and set overflow=1 until reset.
REQ-016 Pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH; level SHALL be updated as +1 (write only), -1 (pop only), or unchanged (both or neither).
REQ-017 full and empty SHALL be registered and derived from the next level value, with no combinational path from wr_en.
REQ-018 A simultaneous write and pop with full=1 SHALL drop the write; with empty=1, the pop cannot occur (REQ-020), so only the write takes effect.
REQ-019 The drain FSM SHALL have the states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-020 In IDLE, with empty=0 and tx_busy=0, the FSM SHALL pop the head byte, register it into tx_din, pulse tx_wr_en for exactly one cycle, and move to WAIT_BUSY.
REQ-021 In WAIT_BUSY, the FSM SHALL move to WAIT_DONE on tx_busy=1 and SHALL NOT issue a new tx_wr_en.
REQ-022 In WAIT_DONE, the FSM SHALL move to IDLE on tx_busy=0.
REQ-023 tx_wr_en SHALL never be high in two consecutive cycles, and SHALL never be high while tx_busy=1.
REQ-024 tx_din SHALL hold its value until the next pop.
REQ-025 Latency: a write accepted at edge k into an empty FIFO with the transmitter idle SHALL give tx_wr_en=1 in the cycle after edge k+1.
REQ-026 Bytes SHALL leave the FIFO in write order, with no duplication or loss except writes dropped under REQ-015.

Reset
REQ-027 On rst=1, regardless of clk, the block SHALL force: pointers=0, level=0, empty=1, full=0, overflow=0, tx_wr_en=0, tx_din=8'h00, state=IDLE.
REQ-028 A reset during WAIT_BUSY or WAIT_DONE SHALL return the FSM to IDLE; the first post-reset issue SHALL wait for tx_busy=0.
REQ-029 FIFO memory contents SHALL NOT require reset.

Structure
REQ-030 The drain-FSM state encodings (2 bits) and the default DEPTH SHALL live in the shared package uart_pkg.
REQ-031 Storage and pointers SHALL be one sub-module, sync_fifo, parameterised on width and depth; uart_tx_fifo instantiates it and contains the drain FSM.

Verification
REQ-032 Single byte: write 8'hA5 with tx_busy=0 -> one tx_wr_en pulse two cycles later, tx_din=8'hA5; empty=1 after the pop.
REQ-033 Burst with a behavioural transmitter model: write 8'h01..8'h10 (16 bytes, DEPTH=16) back-to-back -> full=1 after the 16th write; all 16 bytes are emitted in order, each tx_wr_en only after tx_busy falls.
REQ-034 Overflow: fill 16 bytes, then write 8'hFF -> overflow=1, level stays 16, and 8'hFF is never emitted.
REQ-035 Wrap and concurrency: stream 40 bytes while draining, with simultaneous write and pop cycles -> level is correct on every cycle, output sequence equals input sequence, and pointers wrap at 16.
REQ-036 Reset mid-frame: assert rst in WAIT_DONE with 3 bytes queued -> all outputs take their reset values, level=0, and no tx_wr_en appears until new data is written and tx_busy=0.
REQ-037 Busy held: hold tx_busy=1 at reset release with 2 bytes queued -> no tx_wr_en until tx_busy=0, then exactly one pulse.
